// File: rtl/paddle_match_ctrl_pkg.sv
// rtl/paddle_match_ctrl_pkg.sv - shared state codes, winner codes and default timing for the match sequencer
//
// Purpose: common definitions imported by paddle_match_ctrl and its smash gate.
//   match_state_e : state codes reported on match_state (IDLE=0 .. OVER=4)
//   WIN_*         : winner output codes
//   DEF_*         : default parameter values for the top level
//   width_for()   : bits needed to hold a value 0..max_val (minimum 1)
package paddle_match_ctrl_pkg;

  typedef enum logic [2:0] {
    PARTIDA_IDLE  = 3'd0,
    PARTIDA_SERVE = 3'd1,
    PARTIDA_PLAY  = 3'd2,
    PARTIDA_POINT = 3'd3,
    PARTIDA_OVER  = 3'd4
  } match_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int DEF_TICK_DIV       = 2500000;
  localparam int DEF_SERVE_TICKS    = 40;
  localparam int DEF_POINT_TICKS    = 20;
  localparam int DEF_WIN_SCORE      = 7;
  localparam int DEF_SMASH_COOLDOWN = 60;

  function automatic int width_for(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/paddle_match_ctrl_if.sv
// rtl/paddle_match_ctrl_if.sv - button/ball-logic inputs and paddle-side outputs of the match sequencer
//
// Purpose: bundles every non-clock, non-reset signal of paddle_match_ctrl.
//   Inputs to the controller : start_n, smash_btn1_n, smash_btn2_n, ball_out_left, ball_out_right
//   Outputs of the controller: paddle_rst, paddle_freeze, smash1_n, smash2_n, ball_launch,
//                              serve_dir, score1, score2, winner, match_state
// Modports: master = environment (buttons, ball logic, paddles); slave = the controller.
interface paddle_match_ctrl_if;
  logic       start_n;
  logic       smash_btn1_n;
  logic       smash_btn2_n;
  logic       ball_out_left;
  logic       ball_out_right;
  logic       paddle_rst;
  logic       paddle_freeze;
  logic       smash1_n;
  logic       smash2_n;
  logic       ball_launch;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic [2:0] match_state;

  modport master (
    output start_n, smash_btn1_n, smash_btn2_n, ball_out_left, ball_out_right,
    input  paddle_rst, paddle_freeze, smash1_n, smash2_n, ball_launch,
           serve_dir, score1, score2, winner, match_state
  );

  modport slave (
    input  start_n, smash_btn1_n, smash_btn2_n, ball_out_left, ball_out_right,
    output paddle_rst, paddle_freeze, smash1_n, smash2_n, ball_launch,
           serve_dir, score1, score2, winner, match_state
  );
endinterface

// File: rtl/paddle_match_ctrl_smash_gate.sv
// rtl/paddle_match_ctrl_smash_gate.sv - per-player smash button edge detect, cooldown and 1-cycle pulse
//
// Purpose: turns a raw active-low smash button into a single registered active-low pulse.
// Optional macro: SMASH_COOLDOWN_EN adds a cooldown counter (SMASH_COOLDOWN ticks) that drops
// presses arriving before it has run down; without it every enabled press fires.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_n      : raw smash button, active-low
//   enable     : 1 while the match is in live play
//   tick       : game tick strobe (SMASH_COOLDOWN_EN only)
//   clr        : clear the cooldown (SMASH_COOLDOWN_EN only)
//   smash_n    : registered active-low smash request, low for one cycle per accepted press
module paddle_match_ctrl_smash_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic enable,
`ifdef SMASH_COOLDOWN_EN
  input  logic tick,
  input  logic clr,
`endif
  output logic smash_n
);
`ifdef SMASH_COOLDOWN_EN
  import paddle_match_ctrl_pkg::*;
  parameter int SMASH_COOLDOWN = DEF_SMASH_COOLDOWN;
  localparam int CD_W = width_for(SMASH_COOLDOWN);
  logic [CD_W-1:0] cd_q, cd_d;
`endif

  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic smash_n_q, smash_n_d;
  logic fire;

  always_comb begin
    sync_d = btn_n;
    prev_d = sync_q;
    // Falling edge of the synchronised button; a held button stays low and never re-fires.
    fire   = prev_q & ~sync_q & enable;
`ifdef SMASH_COOLDOWN_EN
    if (cd_q != '0) fire = 1'b0;
    cd_d = cd_q;
    if (clr)                         cd_d = '0;
    else if (fire)                   cd_d = CD_W'(SMASH_COOLDOWN);
    else if (tick && (cd_q != '0))   cd_d = cd_q - 1'b1;
`endif
    smash_n_d = ~fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 1'b1;
      prev_q    <= 1'b1;
      smash_n_q <= 1'b1;
`ifdef SMASH_COOLDOWN_EN
      cd_q      <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      smash_n_q <= smash_n_d;
`ifdef SMASH_COOLDOWN_EN
      cd_q      <= cd_d;
`endif
    end
  end

  assign smash_n = smash_n_q;
endmodule

// File: rtl/paddle_match_ctrl.sv
// rtl/paddle_match_ctrl.sv - two-paddle match sequencer: serve countdown, point pause, scoring, game over
//
// Purpose: drives paddle reset/freeze/smash, launches the ball and keeps score.
// Optional macro: SMASH_COOLDOWN_EN enables the per-player smash cooldown.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : paddle_match_ctrl_if.slave (buttons, ball-out pulses in; paddle controls, score, state out)
module paddle_match_ctrl
  import paddle_match_ctrl_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int SERVE_TICKS    = DEF_SERVE_TICKS,
  parameter int POINT_TICKS    = DEF_POINT_TICKS,
  parameter int WIN_SCORE      = DEF_WIN_SCORE,
  parameter int SMASH_COOLDOWN = DEF_SMASH_COOLDOWN
) (
  input  logic               clk,
  input  logic               reset,
  paddle_match_ctrl_if.slave bus
);
  localparam int TICK_W = width_for(TICK_DIV - 1);
  localparam int CNT_W  = width_for((SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS);

  if (TICK_DIV < 1 || SERVE_TICKS < 1 || POINT_TICKS < 1 ||
      WIN_SCORE < 1 || WIN_SCORE > 15 || SMASH_COOLDOWN < 0) begin : g_bad_params
    $error("paddle_match_ctrl: parameter out of range");
  end

  match_state_e      state_q, state_d;
  logic              entry_q, entry_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        score1_q, score1_d;
  logic [3:0]        score2_q, score2_d;
  logic [1:0]        winner_q, winner_d;
  logic              serve_dir_q, serve_dir_d;
  logic              start_sync_q, start_prev_q;
  logic              tick, start_fall, restart, freeze;
  logic              smash1_raw_n, smash2_raw_n;

  assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign start_fall = start_prev_q & ~start_sync_q;
  assign restart    = (state_q == PARTIDA_OVER) && start_fall;

  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;

    unique case (state_q)
      PARTIDA_IDLE: begin
        if (start_fall) begin
          state_d = PARTIDA_SERVE;
          cnt_d   = CNT_W'(SERVE_TICKS);
        end
      end
      PARTIDA_SERVE: begin
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) state_d = PARTIDA_PLAY;
          else                    cnt_d   = cnt_q - 1'b1;
        end
      end
      PARTIDA_PLAY: begin
        if (bus.ball_out_left && bus.ball_out_right) begin
          // Simultaneous goals are treated as a replay: same server, fresh countdown.
          state_d = PARTIDA_SERVE;
          cnt_d   = CNT_W'(SERVE_TICKS);
        end else if (bus.ball_out_right) begin
          score1_d    = score1_q + 4'd1;
          serve_dir_d = 1'b1;
          if (score1_d == 4'(WIN_SCORE)) begin
            state_d  = PARTIDA_OVER;
            winner_d = WIN_P1;
          end else begin
            state_d = PARTIDA_POINT;
            cnt_d   = CNT_W'(POINT_TICKS);
          end
        end else if (bus.ball_out_left) begin
          score2_d    = score2_q + 4'd1;
          serve_dir_d = 1'b0;
          if (score2_d == 4'(WIN_SCORE)) begin
            state_d  = PARTIDA_OVER;
            winner_d = WIN_P2;
          end else begin
            state_d = PARTIDA_POINT;
            cnt_d   = CNT_W'(POINT_TICKS);
          end
        end
      end
      PARTIDA_POINT: begin
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = PARTIDA_SERVE;
            cnt_d   = CNT_W'(SERVE_TICKS);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      PARTIDA_OVER: begin
        if (restart) begin
          state_d  = PARTIDA_SERVE;
          cnt_d    = CNT_W'(SERVE_TICKS);
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = WIN_NONE;
        end
      end
      default: state_d = PARTIDA_IDLE;
    endcase

    // Marks the first cycle of every state: drives the paddle recentre on SERVE and the launch on PLAY.
    entry_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PARTIDA_IDLE;
      entry_q      <= 1'b0;
      tick_cnt_q   <= '0;
      cnt_q        <= '0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= WIN_NONE;
      serve_dir_q  <= 1'b0;
      start_sync_q <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      tick_cnt_q   <= tick_cnt_d;
      cnt_q        <= cnt_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      start_sync_q <= bus.start_n;
      start_prev_q <= start_sync_q;
    end
  end

`ifdef SMASH_COOLDOWN_EN
  paddle_match_ctrl_smash_gate #(.SMASH_COOLDOWN(SMASH_COOLDOWN)) u_smash1 (
    .clk(clk), .rst_n(reset), .btn_n(bus.smash_btn1_n), .enable(state_q == PARTIDA_PLAY),
    .tick(tick), .clr(restart), .smash_n(smash1_raw_n)
  );
  paddle_match_ctrl_smash_gate #(.SMASH_COOLDOWN(SMASH_COOLDOWN)) u_smash2 (
    .clk(clk), .rst_n(reset), .btn_n(bus.smash_btn2_n), .enable(state_q == PARTIDA_PLAY),
    .tick(tick), .clr(restart), .smash_n(smash2_raw_n)
  );
`else
  paddle_match_ctrl_smash_gate u_smash1 (
    .clk(clk), .rst_n(reset), .btn_n(bus.smash_btn1_n), .enable(state_q == PARTIDA_PLAY),
    .smash_n(smash1_raw_n)
  );
  paddle_match_ctrl_smash_gate u_smash2 (
    .clk(clk), .rst_n(reset), .btn_n(bus.smash_btn2_n), .enable(state_q == PARTIDA_PLAY),
    .smash_n(smash2_raw_n)
  );
`endif

  assign freeze            = (state_q != PARTIDA_PLAY);
  assign bus.paddle_freeze = freeze;
  assign bus.paddle_rst    = (state_q == PARTIDA_IDLE) || ((state_q == PARTIDA_SERVE) && entry_q);
  assign bus.ball_launch   = (state_q == PARTIDA_PLAY) && entry_q;
  // Smash requests are forced inactive whenever paddles are frozen, including a press
  // accepted on the final cycle of play.
  assign bus.smash1_n      = smash1_raw_n | freeze;
  assign bus.smash2_n      = smash2_raw_n | freeze;
  assign bus.serve_dir     = serve_dir_q;
  assign bus.score1        = score1_q;
  assign bus.score2        = score2_q;
  assign bus.winner        = winner_q;
  assign bus.match_state   = state_q;
endmodule

// File: tb/tb_paddle_match_ctrl.sv
// tb/tb_paddle_match_ctrl.sv - self-checking bench for paddle_match_ctrl
module tb_paddle_match_ctrl;
  import paddle_match_ctrl_pkg::*;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int PT = 2;
  localparam int WS = 3;
  localparam int CD = 5;
  // {paddle_rst, freeze, smash1_n, smash2_n, ball_launch, serve_dir, winner, score1, score2, state}
  localparam logic [18:0] RST_VEC = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 3'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic exp_dir_q[$];
  bit   exp_sm1_q[$];
  bit   exp_sm2_q[$];

  paddle_match_ctrl_if bus ();

  paddle_match_ctrl #(
    .TICK_DIV(TD), .SERVE_TICKS(ST), .POINT_TICKS(PT), .WIN_SCORE(WS), .SMASH_COOLDOWN(CD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] out_vec();
    return {bus.paddle_rst, bus.paddle_freeze, bus.smash1_n, bus.smash2_n, bus.ball_launch,
            bus.serve_dir, bus.winner, bus.score1, bus.score2, bus.match_state};
  endfunction

  // Scoreboard consumer: every launch / smash pulse must match a queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.ball_launch === 1'b1) begin
        checks++;
        if (exp_dir_q.size() == 0) begin
          errors++; $display("FAIL launch_unexpected: ball_launch=1, no launch expected");
        end else begin
          logic e;
          e = exp_dir_q.pop_front();
          if (bus.serve_dir !== e) begin
            errors++; $display("FAIL launch_dir: serve_dir=%0b expected %0b", bus.serve_dir, e);
          end
        end
      end
      if (bus.smash1_n === 1'b0) begin
        checks++;
        if (exp_sm1_q.size() == 0) begin
          errors++; $display("FAIL smash1_unexpected: smash1_n=0, no pulse expected");
        end else void'(exp_sm1_q.pop_front());
      end
      if (bus.smash2_n === 1'b0) begin
        checks++;
        if (exp_sm2_q.size() == 0) begin
          errors++; $display("FAIL smash2_unexpected: smash2_n=0, no pulse expected");
        end else void'(exp_sm2_q.pop_front());
      end
    end
  end

  task automatic wait_state(input logic [2:0] target, input int bound, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (bus.match_state === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic play_point(input bit right, output bit ok);
    int  c;
    bit  ok1, ok2;
    if (right) bus.ball_out_right = 1'b1; else bus.ball_out_left = 1'b1;
    @(negedge clk);
    bus.ball_out_right = 1'b0;
    bus.ball_out_left  = 1'b0;
    wait_state(PARTIDA_SERVE, PT * TD + 4, c, ok1);
    wait_state(PARTIDA_PLAY, ST * TD + 4, c, ok2);
    ok = ok1 & ok2;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", out_vec(), RST_VEC);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.match_state !== PARTIDA_IDLE || bus.paddle_rst !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset: state=%0d paddle_rst=%0b expected 0/1", bus.match_state, bus.paddle_rst);
    end
  endtask

  task automatic test_start_serve;
    int c;
    bit ok;
    exp_dir_q.push_back(1'b0);
    bus.start_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.match_state !== PARTIDA_IDLE) begin
      errors++; $display("FAIL start_latency: state=%0d expected 0", bus.match_state);
    end
    @(negedge clk);
    checks++;
    if (bus.match_state !== PARTIDA_SERVE || bus.paddle_rst !== 1'b1) begin
      errors++; $display("FAIL serve_entry: state=%0d paddle_rst=%0b expected 1/1", bus.match_state, bus.paddle_rst);
    end
    bus.start_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.paddle_rst !== 1'b0 || bus.paddle_freeze !== 1'b1 || bus.match_state !== PARTIDA_SERVE) begin
      errors++; $display("FAIL serve_hold: rst=%0b freeze=%0b state=%0d expected 0/1/1", bus.paddle_rst, bus.paddle_freeze, bus.match_state);
    end
    wait_state(PARTIDA_PLAY, ST * TD + 4, c, ok);
    checks++;
    if (!ok || (c + 1) < (ST - 1) * TD + 1 || (c + 1) > ST * TD) begin
      errors++; $display("FAIL serve_length: ok=%0b cycles=%0d expected %0d..%0d", ok, c + 1, (ST - 1) * TD + 1, ST * TD);
    end
    checks++;
    if (bus.paddle_freeze !== 1'b0) begin
      errors++; $display("FAIL play_freeze: freeze=%0b expected 0", bus.paddle_freeze);
    end
  endtask

  task automatic test_point;
    int c;
    bit ok;
    exp_dir_q.push_back(1'b1);
    bus.ball_out_right = 1'b1;
    @(negedge clk);
    bus.ball_out_right = 1'b0;
    checks++;
    if (bus.match_state !== PARTIDA_POINT || bus.score1 !== 4'd1 || bus.score2 !== 4'd0 || bus.paddle_freeze !== 1'b1) begin
      errors++; $display("FAIL point_score: state=%0d s1=%0d s2=%0d freeze=%0b expected 3/1/0/1",
                         bus.match_state, bus.score1, bus.score2, bus.paddle_freeze);
    end
    wait_state(PARTIDA_SERVE, PT * TD + 4, c, ok);
    checks++;
    if (!ok || c < (PT - 1) * TD + 1 || c > PT * TD) begin
      errors++; $display("FAIL point_length: ok=%0b cycles=%0d expected %0d..%0d", ok, c, (PT - 1) * TD + 1, PT * TD);
    end
    checks++;
    if (bus.paddle_rst !== 1'b1) begin
      errors++; $display("FAIL reserve_paddle_rst: paddle_rst=%0b expected 1", bus.paddle_rst);
    end
    wait_state(PARTIDA_PLAY, ST * TD + 4, c, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL point_replay_timeout: state=%0d expected 2", bus.match_state);
    end
  endtask

  task automatic test_replay;
    int c;
    bit ok;
    exp_dir_q.push_back(1'b1);
    bus.ball_out_right = 1'b1;
    bus.ball_out_left  = 1'b1;
    @(negedge clk);
    bus.ball_out_right = 1'b0;
    bus.ball_out_left  = 1'b0;
    checks++;
    if (bus.match_state !== PARTIDA_SERVE || bus.score1 !== 4'd1 || bus.score2 !== 4'd0 || bus.paddle_rst !== 1'b1) begin
      errors++; $display("FAIL replay: state=%0d s1=%0d s2=%0d rst=%0b expected 1/1/0/1",
                         bus.match_state, bus.score1, bus.score2, bus.paddle_rst);
    end
    wait_state(PARTIDA_PLAY, ST * TD + 4, c, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL replay_timeout: state=%0d expected 2", bus.match_state);
    end
  endtask

  task automatic test_smash;
    exp_sm1_q.push_back(1'b1);
    bus.smash_btn1_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.smash1_n !== 1'b1) begin
      errors++; $display("FAIL smash_early: smash1_n=%0b expected 1", bus.smash1_n);
    end
    @(negedge clk);
    checks++;
    if (bus.smash1_n !== 1'b0) begin
      errors++; $display("FAIL smash_pulse: smash1_n=%0b expected 0", bus.smash1_n);
    end
    repeat (3) @(negedge clk);
    bus.smash_btn1_n = 1'b1;
    repeat (2) @(negedge clk);
`ifndef SMASH_COOLDOWN_EN
    exp_sm1_q.push_back(1'b1);
`endif
    bus.smash_btn1_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.smash_btn1_n = 1'b1;
    #1;
    checks++;
    if (exp_sm1_q.size() != 0) begin
      errors++; $display("FAIL smash_repress: %0d pulses missing, expected 0", exp_sm1_q.size());
    end
    repeat (CD * TD + 4) @(negedge clk);
    exp_sm1_q.push_back(1'b1);
    exp_sm2_q.push_back(1'b1);
    bus.smash_btn1_n = 1'b0;
    bus.smash_btn2_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.smash_btn1_n = 1'b1;
    bus.smash_btn2_n = 1'b1;
    #1;
    checks++;
    if (exp_sm1_q.size() != 0 || exp_sm2_q.size() != 0) begin
      errors++; $display("FAIL smash_both: missing p1=%0d p2=%0d expected 0/0", exp_sm1_q.size(), exp_sm2_q.size());
    end
  endtask

  task automatic test_game_over;
    int c;
    bit ok;
    bus.start_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.start_n = 1'b1;
    checks++;
    if (bus.match_state !== PARTIDA_PLAY) begin
      errors++; $display("FAIL start_in_play: state=%0d expected 2", bus.match_state);
    end
    exp_dir_q.push_back(1'b1);
    play_point(1'b1, ok);
    checks++;
    if (!ok || bus.score1 !== 4'd2) begin
      errors++; $display("FAIL second_point: ok=%0b s1=%0d expected 1/2", ok, bus.score1);
    end
    bus.ball_out_right = 1'b1;
    @(negedge clk);
    bus.ball_out_right = 1'b0;
    checks++;
    if (bus.match_state !== PARTIDA_OVER || bus.winner !== WIN_P1 || bus.score1 !== 4'd3 || bus.paddle_freeze !== 1'b1) begin
      errors++; $display("FAIL game_over: state=%0d winner=%b s1=%0d freeze=%0b expected 4/01/3/1",
                         bus.match_state, bus.winner, bus.score1, bus.paddle_freeze);
    end
    bus.ball_out_left = 1'b1;
    @(negedge clk);
    bus.ball_out_left = 1'b0;
    bus.smash_btn1_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.smash_btn1_n = 1'b1;
    checks++;
    if (bus.score2 !== 4'd0 || bus.match_state !== PARTIDA_OVER) begin
      errors++; $display("FAIL over_ignores_ball: s2=%0d state=%0d expected 0/4", bus.score2, bus.match_state);
    end
    exp_dir_q.push_back(1'b1);
    bus.start_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.start_n = 1'b1;
    checks++;
    if (bus.match_state !== PARTIDA_SERVE || bus.score1 !== 4'd0 || bus.winner !== WIN_NONE || bus.paddle_rst !== 1'b1) begin
      errors++; $display("FAIL restart: state=%0d s1=%0d winner=%b rst=%0b expected 1/0/00/1",
                         bus.match_state, bus.score1, bus.winner, bus.paddle_rst);
    end
    wait_state(PARTIDA_PLAY, ST * TD + 4, c, ok);
    #1;
    checks++;
    if (!ok || exp_dir_q.size() != 0) begin
      errors++; $display("FAIL restart_launch: ok=%0b pending=%0d expected 1/0", ok, exp_dir_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ok1, ok2;
    exp_dir_q.push_back(1'b0);
    @(negedge clk);
    play_point(1'b0, ok1);
    exp_dir_q.push_back(1'b0);
    play_point(1'b0, ok2);
    checks++;
    if (!ok1 || !ok2 || bus.score2 !== 4'd2 || bus.match_state !== PARTIDA_PLAY) begin
      errors++; $display("FAIL left_points: ok=%0b%0b s2=%0d state=%0d expected 11/2/2", ok1, ok2, bus.score2, bus.match_state);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL async_reset: got %b expected %b", out_vec(), RST_VEC);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.match_state !== PARTIDA_IDLE || exp_dir_q.size() != 0 || exp_sm1_q.size() != 0 || exp_sm2_q.size() != 0) begin
      errors++; $display("FAIL final_state: state=%0d pending=%0d/%0d/%0d expected 0/0/0/0",
                         bus.match_state, exp_dir_q.size(), exp_sm1_q.size(), exp_sm2_q.size());
    end
  endtask

  initial begin
    bus.start_n        = 1'b1;
    bus.smash_btn1_n   = 1'b1;
    bus.smash_btn2_n   = 1'b1;
    bus.ball_out_left  = 1'b0;
    bus.ball_out_right = 1'b0;
    reset              = 1'b0;
    test_reset();
    test_start_serve();
    test_point();
    test_replay();
    test_smash();
    test_game_over();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
